// File: rtl/data_memory_arbiter_if.sv
// Bundle of both requester ports, the shared data_memory port and the boost status.
// The arbiter uses the slave modport; whoever drives the requests uses master.
interface data_memory_arbiter_if #(
  parameter int D = 6,
  parameter int W = 32
);
  logic         p0_valid;
  logic         p0_we;
  logic [D-1:0] p0_addr;
  logic [W-1:0] p0_wdata;
  logic         p0_ready;
  logic         p0_rvalid;
  logic [W-1:0] p0_rdata;

  logic         p1_valid;
  logic         p1_we;
  logic [D-1:0] p1_addr;
  logic [W-1:0] p1_wdata;
  logic         p1_ready;
  logic         p1_rvalid;
  logic [W-1:0] p1_rdata;

  logic         mem_write_enable;
  logic [D-1:0] mem_address;
  logic [W-1:0] mem_data_in;
  logic [W-1:0] mem_data_out;
  logic         starve_boost;

  modport master (
    output p0_valid, p0_we, p0_addr, p0_wdata,
    input  p0_ready, p0_rvalid, p0_rdata,
    output p1_valid, p1_we, p1_addr, p1_wdata,
    input  p1_ready, p1_rvalid, p1_rdata,
    input  mem_write_enable, mem_address, mem_data_in, starve_boost,
    output mem_data_out
  );

  modport slave (
    input  p0_valid, p0_we, p0_addr, p0_wdata,
    output p0_ready, p0_rvalid, p0_rdata,
    input  p1_valid, p1_we, p1_addr, p1_wdata,
    output p1_ready, p1_rvalid, p1_rdata,
    output mem_write_enable, mem_address, mem_data_in, starve_boost,
    input  mem_data_out
  );
endinterface

// File: rtl/data_memory_arbiter.sv
// Two-port arbiter in front of the single-port data_memory: port 0 normally wins,
// port 1 is boosted after STARVE_LIMIT consecutive stalled cycles.
module data_memory_arbiter #(
  parameter int D            = 6,
  parameter int W            = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic                 clk,
  input logic                 rst,
  data_memory_arbiter_if.slave bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] r_starveCnt;
  logic          r_rvalid0;
  logic          r_rvalid1;
  logic [W-1:0]  r_rdata0;
  logic [W-1:0]  r_rdata1;

  logic          w_boost;
  logic          w_grant0;
  logic          w_grant1;
  logic          w_memWe;
  logic [D-1:0]  w_memAddr;
  logic [W-1:0]  w_memWdata;

  assign w_boost = !rst && (r_starveCnt == CW'(STARVE_LIMIT));

  // Everything combinational is held at zero while reset is asserted.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (!rst) begin
      w_grant1 = bus.p1_valid && (!bus.p0_valid || w_boost);
      w_grant0 = bus.p0_valid && !w_grant1;
    end
  end

  always_comb begin
    w_memWe    = 1'b0;
    w_memAddr  = '0;
    w_memWdata = '0;
    if (w_grant0) begin
      w_memWe    = bus.p0_we;
      w_memAddr  = bus.p0_addr;
      w_memWdata = bus.p0_wdata;
    end else if (w_grant1) begin
      w_memWe    = bus.p1_we;
      w_memAddr  = bus.p1_addr;
      w_memWdata = bus.p1_wdata;
    end
  end

  // Read data is captured from the asynchronous memory output at the end of the accept cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starveCnt <= '0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
    end else begin
      r_rvalid0 <= w_grant0 && !bus.p0_we;
      r_rvalid1 <= w_grant1 && !bus.p1_we;
      if (w_grant0 && !bus.p0_we) begin
        r_rdata0 <= bus.mem_data_out;
      end
      if (w_grant1 && !bus.p1_we) begin
        r_rdata1 <= bus.mem_data_out;
      end
      if (!bus.p1_valid || w_grant1) begin
        r_starveCnt <= '0;
      end else if (r_starveCnt != CW'(STARVE_LIMIT)) begin
        r_starveCnt <= r_starveCnt + 1'b1;
      end
    end
  end

  assign bus.p0_ready         = w_grant0;
  assign bus.p1_ready         = w_grant1;
  assign bus.p0_rvalid        = r_rvalid0;
  assign bus.p1_rvalid        = r_rvalid1;
  assign bus.p0_rdata         = r_rdata0;
  assign bus.p1_rdata         = r_rdata1;
  assign bus.mem_write_enable = w_memWe;
  assign bus.mem_address      = w_memAddr;
  assign bus.mem_data_in      = w_memWdata;
  assign bus.starve_boost     = w_boost;
endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a behavioural data_memory model
// (synchronous write, asynchronous read).
module tb_data_memory_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [31:0] memModel [64];

  data_memory_arbiter_if #(.D(6), .W(32)) bus ();

  data_memory_arbiter #(.D(6), .W(32), .STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign bus.mem_data_out = memModel[bus.mem_address];

  always @(posedge clk) begin
    if (bus.mem_write_enable) memModel[bus.mem_address] <= bus.mem_data_in;
  end

  typedef struct {
    logic        v0;
    logic        we0;
    logic [5:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic        we1;
    logic [5:0]  a1;
    logic [31:0] d1;
    logic        er0;
    logic        er1;
    logic        ewe;
    logic [5:0]  eaddr;
    logic [31:0] edin;
    logic        erv0;
    logic [31:0] erd0;
    logic        erv1;
    logic [31:0] erd1;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v0, input logic we0, input logic [5:0] a0,
                               input logic [31:0] d0, input logic v1, input logic we1,
                               input logic [5:0] a1, input logic [31:0] d1);
    bus.p0_valid = v0;
    bus.p0_we    = we0;
    bus.p0_addr  = a0;
    bus.p0_wdata = d0;
    bus.p1_valid = v1;
    bus.p1_we    = we1;
    bus.p1_addr  = a1;
    bus.p1_wdata = d1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the end of the test");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 64; i++) memModel[i] = 32'hA000 + i;

    //          v0 we0 a0  d0          v1 we1 a1  d1          r0 r1 we addr din        rv0 rd0          rv1 rd1
    vecs[0]  = '{0, 0, 0,  32'h0,      0, 0,  0,  32'h0,      0, 0, 0, 0,  32'h0,      0, 32'h0,      0, 32'h0};
    vecs[1]  = '{1, 1, 5,  32'h32,     0, 0,  0,  32'h0,      1, 0, 1, 5,  32'h32,     0, 32'h0,      0, 32'h0};
    vecs[2]  = '{1, 0, 5,  32'h77,     0, 0,  0,  32'h0,      1, 0, 0, 5,  32'h77,     1, 32'h32,     0, 32'h0};
    vecs[3]  = '{0, 0, 0,  32'h0,      1, 1,  7,  32'h1234,   0, 1, 1, 7,  32'h1234,   0, 32'h0,      0, 32'h0};
    vecs[4]  = '{0, 0, 0,  32'h0,      1, 0,  7,  32'h0,      0, 1, 0, 7,  32'h0,      0, 32'h0,      1, 32'h1234};
    vecs[5]  = '{1, 0, 5,  32'h0,      1, 0,  7,  32'h0,      1, 0, 0, 5,  32'h0,      1, 32'h32,     0, 32'h0};
    vecs[6]  = '{1, 0, 7,  32'h0,      0, 0,  0,  32'h0,      1, 0, 0, 7,  32'h0,      1, 32'h1234,   0, 32'h0};
    vecs[7]  = '{0, 0, 0,  32'h0,      1, 0,  9,  32'h55,     0, 1, 0, 9,  32'h55,     0, 32'h0,      1, 32'hA009};
    vecs[8]  = '{1, 1, 9,  32'hBEEF,   1, 1,  10, 32'hCAFE,   1, 0, 1, 9,  32'hBEEF,   0, 32'h0,      0, 32'h0};
    vecs[9]  = '{1, 0, 9,  32'h0,      1, 1,  10, 32'hCAFE,   1, 0, 0, 9,  32'h0,      1, 32'hBEEF,   0, 32'h0};
    vecs[10] = '{0, 0, 0,  32'h0,      1, 1,  10, 32'hCAFE,   0, 1, 1, 10, 32'hCAFE,   0, 32'h0,      0, 32'h0};
    vecs[11] = '{0, 0, 0,  32'h0,      1, 0,  10, 32'h0,      0, 1, 0, 10, 32'h0,      0, 32'h0,      1, 32'hCAFE};

    // Reset held with both requesters asking: everything must stay quiet.
    rst = 1'b1;
    applyStimulus(1, 1, 6'd2, 32'h11, 1, 0, 6'd4, 32'h22);
    tick();
    tick();
    #2;
    checkOutput("rst p0_ready", 32'(bus.p0_ready), 0);
    checkOutput("rst p1_ready", 32'(bus.p1_ready), 0);
    checkOutput("rst p0_rvalid", 32'(bus.p0_rvalid), 0);
    checkOutput("rst p1_rvalid", 32'(bus.p1_rvalid), 0);
    checkOutput("rst p0_rdata", bus.p0_rdata, 0);
    checkOutput("rst p1_rdata", bus.p1_rdata, 0);
    checkOutput("rst mem_we", 32'(bus.mem_write_enable), 0);
    checkOutput("rst mem_addr", 32'(bus.mem_address), 0);
    checkOutput("rst boost", 32'(bus.starve_boost), 0);
    tick();
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Table of single-cycle transactions.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].v0, vecs[i].we0, vecs[i].a0, vecs[i].d0,
                    vecs[i].v1, vecs[i].we1, vecs[i].a1, vecs[i].d1);
      #2;
      checkOutput($sformatf("vec%0d p0_ready", i), 32'(bus.p0_ready), 32'(vecs[i].er0));
      checkOutput($sformatf("vec%0d p1_ready", i), 32'(bus.p1_ready), 32'(vecs[i].er1));
      checkOutput($sformatf("vec%0d mem_we", i), 32'(bus.mem_write_enable), 32'(vecs[i].ewe));
      checkOutput($sformatf("vec%0d mem_addr", i), 32'(bus.mem_address), 32'(vecs[i].eaddr));
      checkOutput($sformatf("vec%0d mem_din", i), bus.mem_data_in, vecs[i].edin);
      tick();
      checkOutput($sformatf("vec%0d p0_rvalid", i), 32'(bus.p0_rvalid), 32'(vecs[i].erv0));
      checkOutput($sformatf("vec%0d p1_rvalid", i), 32'(bus.p1_rvalid), 32'(vecs[i].erv1));
      if (vecs[i].erv0) checkOutput($sformatf("vec%0d p0_rdata", i), bus.p0_rdata, vecs[i].erd0);
      if (vecs[i].erv1) checkOutput($sformatf("vec%0d p1_rdata", i), bus.p1_rdata, vecs[i].erd1);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Starvation: p0 reads continuously, p1 waits four cycles then gets boosted.
    applyStimulus(1, 0, 6'd0, 0, 1, 0, 6'd1, 0);
    for (int c = 1; c <= 4; c++) begin
      #2;
      checkOutput($sformatf("starve c%0d p0_ready", c), 32'(bus.p0_ready), 1);
      checkOutput($sformatf("starve c%0d p1_ready", c), 32'(bus.p1_ready), 0);
      checkOutput($sformatf("starve c%0d boost", c), 32'(bus.starve_boost), 0);
      tick();
    end
    #2;
    checkOutput("starve c5 boost", 32'(bus.starve_boost), 1);
    checkOutput("starve c5 p1_ready", 32'(bus.p1_ready), 1);
    checkOutput("starve c5 p0_ready", 32'(bus.p0_ready), 0);
    tick();
    checkOutput("starve p1_rvalid", 32'(bus.p1_rvalid), 1);
    checkOutput("starve p1_rdata", bus.p1_rdata, 32'hA001);
    checkOutput("starve boost cleared", 32'(bus.starve_boost), 0);
    applyStimulus(1, 0, 6'd0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("starve after p0_ready", 32'(bus.p0_ready), 1);
    tick();
    checkOutput("starve after p0_rdata", bus.p0_rdata, 32'hA000);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // p0 write and p1 read to the same address in the same cycle.
    applyStimulus(1, 1, 6'd3, 32'hAB, 1, 0, 6'd3, 0);
    #2;
    checkOutput("wr-rd N p0_ready", 32'(bus.p0_ready), 1);
    checkOutput("wr-rd N p1_ready", 32'(bus.p1_ready), 0);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 0, 6'd3, 0);
    #2;
    checkOutput("wr-rd N+1 p1_ready", 32'(bus.p1_ready), 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("wr-rd N+2 p1_rvalid", 32'(bus.p1_rvalid), 1);
    checkOutput("wr-rd N+2 p1_rdata", bus.p1_rdata, 32'hAB);
    tick();

    // Reset arriving between read accept and response drops the response.
    applyStimulus(1, 0, 6'd3, 0, 0, 0, 0, 0);
    #2;
    checkOutput("midrst p0_ready", 32'(bus.p0_ready), 1);
    #1;
    rst = 1'b1;
    tick();
    checkOutput("midrst p0_rvalid", 32'(bus.p0_rvalid), 0);
    checkOutput("midrst p0_rdata", bus.p0_rdata, 0);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("midrst after p0_rvalid", 32'(bus.p0_rvalid), 0);
    checkOutput("midrst after p0_rdata", bus.p0_rdata, 0);
    applyStimulus(1, 0, 6'd3, 0, 0, 0, 0, 0);
    #2;
    checkOutput("resume p0_ready", 32'(bus.p0_ready), 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("resume p0_rvalid", 32'(bus.p0_rvalid), 1);
    checkOutput("resume p0_rdata", bus.p0_rdata, 32'hAB);
    tick();

    // Port 1 fills the whole memory, then streams it back one read per cycle.
    for (int a = 0; a < 64; a++) begin
      applyStimulus(0, 0, 0, 0, 1, 1, 6'(a), 32'(a * 10));
      #2;
      checkOutput($sformatf("fill a%0d p1_ready", a), 32'(bus.p1_ready), 1);
      tick();
    end
    for (int a = 0; a < 64; a++) begin
      applyStimulus(0, 0, 0, 0, 1, 0, 6'(a), 0);
      tick();
      checkOutput($sformatf("dump a%0d p1_rvalid", a), 32'(bus.p1_rvalid), 1);
      checkOutput($sformatf("dump a%0d p1_rdata", a), bus.p1_rdata, 32'(a * 10));
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("idle p1_rvalid", 32'(bus.p1_rvalid), 0);
    checkOutput("idle p1_rdata held", bus.p1_rdata, 32'h276);
    checkOutput("idle mem_we", 32'(bus.mem_write_enable), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
